// File: rtl/ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
// Shared types and defaults for the 8-bit signed ULA and the accumulator
// sequencer that drives it.
//   ula_op_t   : ULA function select encoding (F input of the ULA)
//   state_t    : sequencer FSM states, also exported on a debug port
//   ULA_WIDTH  : default data width (signed two's complement)
//   ULA_CNT_W  : default width of the completed-operation counter
// ---------------------------------------------------------------------------
package ula_pkg;

  localparam int ULA_WIDTH = 8;
  localparam int ULA_CNT_W = 8;

  typedef enum logic [1:0] {
    ULA_AND = 2'b00,
    ULA_OR  = 2'b01,
    ULA_ADD = 2'b10,
    ULA_SUB = 2'b11
  } ula_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage : ula_pkg

// File: rtl/ula.sv
// ---------------------------------------------------------------------------
// ula
// Purely combinational signed ULA. Instantiated beside ula_acc_ctrl at the
// top level (A/B/F from the sequencer, Saida/FLAG_O back into it).
// Ports:
//   A, B    in   WIDTH  signed operands
//   F       in   2      function: 00 AND, 01 OR, 10 ADD, 11 SUB
//   Saida   out  WIDTH  result, two's-complement wrap for ADD/SUB
//   FLAG_O  out  1      signed overflow/underflow of ADD/SUB, 0 for logic ops
// ---------------------------------------------------------------------------
module ula
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       F,
  output logic [WIDTH-1:0] Saida,
  output logic             FLAG_O
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = A + B;
  assign diff = A - B;

  always_comb begin
    Saida  = '0;
    FLAG_O = 1'b0;
    case (ula_op_t'(F))
      ULA_AND: Saida = A & B;
      ULA_OR:  Saida = A | B;
      ULA_ADD: begin
        Saida  = sum;
        // Same-sign operands producing an opposite-sign sum.
        FLAG_O = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      ULA_SUB: begin
        Saida  = diff;
        // Opposite-sign operands where the result takes the sign of B.
        FLAG_O = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      default: begin
        Saida  = '0;
        FLAG_O = 1'b0;
      end
    endcase
  end

endmodule : ula

// File: rtl/ula_acc_ctrl.sv
// ---------------------------------------------------------------------------
// ula_acc_ctrl
// Accumulator/sequencer around the signed ULA. A command is accepted in IDLE,
// its operands are registered towards the ULA (A = accumulator, B = command
// data), the ULA result is captured in EXEC and returned in RESP.
//
// Handshakes (both sides): a transfer happens on the rising clock edge where
// valid && ready are both high. A producer holds valid and its payload stable
// until that edge. cmd_ready is high only in IDLE; res_valid is high only in
// RESP, with res_data/res_ovf stable until the transfer.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cmd_valid/ready     command handshake
//   cmd_load            1: load cmd_data into acc (ULA bypassed), 0: ULA op
//   cmd_f               ULA function
//   cmd_clr             clear op_count/ovf_sticky when this op completes
//   cmd_data            operand B / load value
//   ula_a/b/f           registered operands to the ULA
//   ula_saida/flag_o    ULA result and overflow flag
//   res_valid/ready     result handshake
//   res_data            accumulator after the op
//   res_ovf             overflow of this op (0 for load)
//   ovf_sticky          OR of res_ovf since reset/clear
//   op_count            completed ops, saturating
//   dbg_state           current FSM state
// ---------------------------------------------------------------------------
module ula_acc_ctrl
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH,
  parameter int CNT_W = ULA_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [1:0]       cmd_f,
  input  logic             cmd_clr,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [1:0]       ula_f,
  input  logic [WIDTH-1:0] ula_saida,
  input  logic             ula_flag_o,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] op_count,
  output state_t           dbg_state
);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] acc;
  logic             load_q;
  logic             clr_q;
  logic             cmd_fire;
  logic             res_fire;

  // Next-state and handshake outputs depend on state only (plus the
  // incoming valid/ready for the transitions).
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = EXEC;
      end
      EXEC: begin
        state_nx = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign cmd_fire = cmd_valid && cmd_ready;
  assign res_fire = res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      ula_a      <= '0;
      ula_b      <= '0;
      ula_f      <= 2'b00;
      load_q     <= 1'b0;
      clr_q      <= 1'b0;
      res_ovf    <= 1'b0;
      ovf_sticky <= 1'b0;
      op_count   <= '0;
    end else begin
      state <= state_nx;

      // Operands only move on acceptance; they hold through EXEC/RESP so the
      // ULA output stays valid while it is being captured.
      if (cmd_fire) begin
        ula_a  <= acc;
        ula_b  <= cmd_data;
        ula_f  <= cmd_f;
        load_q <= cmd_load;
        clr_q  <= cmd_clr;
      end

      if (state == EXEC) begin
        acc     <= load_q ? ula_b : ula_saida;
        res_ovf <= load_q ? 1'b0 : ula_flag_o;
      end

      // Bookkeeping happens at result delivery; a clear request overrides
      // the increment and sticky update of its own op.
      if (res_fire) begin
        if (clr_q) begin
          op_count   <= '0;
          ovf_sticky <= 1'b0;
        end else begin
          if (op_count != {CNT_W{1'b1}}) op_count <= op_count + 1'b1;
          ovf_sticky <= ovf_sticky | res_ovf;
        end
      end
    end
  end

  assign res_data  = acc;
  assign dbg_state = state;

endmodule : ula_acc_ctrl

// File: tb/tb_ula_acc_ctrl.sv
module tb_ula_acc_ctrl;
  import ula_pkg::*;

  localparam int W  = 8;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_load, cmd_clr;
  logic [1:0]    cmd_f;
  logic [W-1:0]  cmd_data;
  logic [W-1:0]  ula_a, ula_b, ula_saida;
  logic [1:0]    ula_f;
  logic          ula_flag_o;
  logic          res_valid, res_ready, res_ovf, ovf_sticky;
  logic [W-1:0]  res_data;
  logic [CW-1:0] op_count;
  state_t        dbg_state;

  ula #(.WIDTH(W)) u_ula (
    .A(ula_a), .B(ula_b), .F(ula_f), .Saida(ula_saida), .FLAG_O(ula_flag_o)
  );

  ula_acc_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_f(cmd_f), .cmd_clr(cmd_clr), .cmd_data(cmd_data),
    .ula_a(ula_a), .ula_b(ula_b), .ula_f(ula_f),
    .ula_saida(ula_saida), .ula_flag_o(ula_flag_o),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_ovf(res_ovf), .ovf_sticky(ovf_sticky), .op_count(op_count),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [W-1:0]  data;
    logic          ovf;
    logic          sticky;
    logic [CW-1:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Accumulator kept as a plain signed integer in [-128, 127].
  int   m_acc;
  logic m_sticky;
  int   m_count;

  function automatic int wrap8(input int v);
    int r;
    r = v % 256;
    if (r < 0) r += 256;
    if (r > 127) r -= 256;
    return r;
  endfunction

  task automatic model_push(input logic load, input logic [1:0] f, input logic clr,
                            input logic [W-1:0] data);
    int   b, s;
    logic ovf;
    logic [W-1:0] a_bits, r_bits;
    exp_t e;
    b   = int'($signed(data));
    ovf = 1'b0;
    a_bits = m_acc[W-1:0];
    if (load) begin
      m_acc = b;
    end else begin
      case (f)
        2'b00: begin r_bits = a_bits & data; m_acc = int'($signed(r_bits)); end
        2'b01: begin r_bits = a_bits | data; m_acc = int'($signed(r_bits)); end
        2'b10: begin s = m_acc + b; ovf = (s > 127) || (s < -128); m_acc = wrap8(s); end
        default: begin s = m_acc - b; ovf = (s > 127) || (s < -128); m_acc = wrap8(s); end
      endcase
    end
    if (clr) begin
      m_sticky = 1'b0;
      m_count  = 0;
    end else begin
      m_sticky = m_sticky | ovf;
      if (m_count < CNT_MAX) m_count++;
    end
    e.data   = m_acc[W-1:0];
    e.ovf    = ovf;
    e.sticky = m_sticky;
    e.count  = m_count[CW-1:0];
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  logic post_pending = 1'b0;
  exp_t post_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      post_pending = 1'b0;
    end else begin
      if (post_pending) begin
        check("ovf_sticky_after", 32'(ovf_sticky), 32'(post_exp.sticky));
        check("op_count_after", 32'(op_count), 32'(post_exp.count));
        post_pending = 1'b0;
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
        end else begin
          post_exp = exp_q.pop_front();
          check("res_data", 32'(res_data), 32'(post_exp.data));
          check("res_ovf", 32'(res_ovf), 32'(post_exp.ovf));
          post_pending = 1'b1;
        end
      end
    end
  end

  // ---------------- res_ready driver ----------------
  logic rr_random = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_random) res_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  // Returns at #1 after the accepting edge (DUT then in EXEC).
  task automatic send(input logic load, input logic [1:0] f, input logic clr,
                      input logic [W-1:0] data, input bit chk_lat);
    int n;
    cmd_load  = load;
    cmd_f     = f;
    cmd_clr   = clr;
    cmd_data  = data;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
    end else begin
      model_push(load, f, clr, data);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (chk_lat) begin
        check("lat_not_valid_1cyc", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_valid_2cyc", 32'(res_valid), 32'd1);
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((dbg_state != IDLE || exp_q.size() != 0) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 400) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    m_acc = 0; m_sticky = 1'b0; m_count = 0;
    exp_q.delete();
  endtask

  // ---------------- main ----------------
  initial begin
    logic [W-1:0] held;
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_f = 2'b00;
    cmd_clr = 1'b0; cmd_data = '0; res_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_ovf", 32'(res_ovf), 32'd0);
    check("rst_sticky", 32'(ovf_sticky), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_ula_a", 32'(ula_a), 32'd0);
    check("rst_ula_b", 32'(ula_b), 32'd0);
    check("rst_ula_f", 32'(ula_f), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    res_ready = 1'b1;

    // Load then add, with latency check
    send(1'b1, ULA_AND, 1'b0, 8'd5, 1'b0);
    send(1'b0, ULA_ADD, 1'b0, 8'd3, 1'b1);
    wait_idle();
    check("load_add_acc", 32'(res_data), 32'd8);

    // Overflow wrap
    send(1'b1, ULA_AND, 1'b0, 8'd127, 1'b0);
    send(1'b0, ULA_ADD, 1'b0, 8'd1, 1'b0);
    wait_idle();
    check("wrap_add", 32'(res_data), 32'h80);
    check("wrap_sticky", 32'(ovf_sticky), 32'd1);
    send(1'b0, ULA_SUB, 1'b0, 8'd1, 1'b0);
    wait_idle();
    check("wrap_sub", 32'(res_data), 32'd127);

    // Logic ops
    send(1'b1, ULA_AND, 1'b0, 8'hF0, 1'b0);
    send(1'b0, ULA_AND, 1'b0, 8'h3C, 1'b0);
    wait_idle();
    check("and_res", 32'(res_data), 32'h30);
    send(1'b0, ULA_OR, 1'b0, 8'h0F, 1'b0);
    wait_idle();
    check("or_res", 32'(res_data), 32'h3F);

    // Backpressure: result held, stray command ignored
    @(posedge clk); #1;
    res_ready = 1'b0;
    send(1'b0, ULA_ADD, 1'b0, 8'h11, 1'b0);
    n = 0;
    while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("bp_valid_rise", 32'(res_valid), 32'd1);
    held = res_data;
    check("bp_data", 32'(held), 32'h50);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_data = 8'h55; cmd_clr = 1'b0;
      end
      if (i == 2) cmd_valid = 1'b0;
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(res_valid), 32'd1);
      check("bp_hold_data", 32'(res_data), 32'(held));
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle();

    // Saturation and clear
    send(1'b1, ULA_AND, 1'b1, 8'h40, 1'b0);
    wait_idle();
    check("clr_count", 32'(op_count), 32'd0);
    for (int i = 0; i < 5; i++) send(1'b0, ULA_ADD, 1'b0, 8'h40, 1'b0);
    wait_idle();
    check("sat_count", 32'(op_count), 32'd3);
    check("sat_sticky", 32'(ovf_sticky), 32'd1);
    send(1'b0, ULA_OR, 1'b1, 8'h01, 1'b0);
    wait_idle();
    check("clr_count2", 32'(op_count), 32'd0);
    check("clr_sticky2", 32'(ovf_sticky), 32'd0);

    // Randomized traffic with random backpressure
    rr_random = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0), 8'($urandom_range(0, 255)), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    @(posedge clk); #1;
    rr_random = 1'b0;
    res_ready = 1'b1;
    wait_idle();

    // Reset mid-op
    send(1'b1, ULA_AND, 1'b0, 8'h22, 1'b0);
    wait_idle();
    send(1'b0, ULA_ADD, 1'b0, 8'h05, 1'b0);
    check("mid_in_exec", 32'(dbg_state), 32'(EXEC));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_state", 32'(dbg_state), 32'(IDLE));
    check("mid_res_valid", 32'(res_valid), 32'd0);
    check("mid_op_count", 32'(op_count), 32'd0);
    check("mid_res_data", 32'(res_data), 32'd0);
    rst_n = 1'b1;
    model_reset();
    send(1'b0, ULA_ADD, 1'b0, 8'h00, 1'b0);
    wait_idle();
    check("post_rst_acc", 32'(res_data), 32'd0);
    check("post_rst_count", 32'(op_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ula_acc_ctrl
